// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the VGA raster generator: default 640x480@60
// porch/sync widths, derived totals, the coordinate type and the window decode
// helper used for the sync and active-video flags.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  // Largest total that still fits the 10-bit coordinate type
  localparam int COORD_LIMIT = 1024;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Half-open window test: lo <= v < hi
  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_counter.sv
// Modulo-MAX counter with enable. wrap is high in the cycle where the counter
// sits at MAX-1 and is enabled, i.e. the edge that returns it to zero.
module vga_wrap_counter #(
  parameter int MAX = 800,
  parameter int W   = 10
) (
  input  logic         vga_clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap = en && (cnt_q == W'(MAX - 1));
  assign q    = cnt_q;

  // Next count: clear on wrap, otherwise step when enabled
  always_comb begin
    cnt_d = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel coordinate, active-video flag and active-low
// hs/vs. The flags are registered from the next-state coordinates so that all
// five outputs change on the same edge with no skew.
// Optional feature: define VGA_FRAME_CNT_EN to add frame_start/frame_count.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic        frame_start,
  output logic [15:0] frame_count
`endif
);

  localparam int HT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_LO = H_VISIBLE + H_FRONT;
  localparam int HS_HI = HS_LO + H_SYNC;
  localparam int VS_LO = V_VISIBLE + V_FRONT;
  localparam int VS_HI = VS_LO + V_SYNC;

  generate
    if (HT > COORD_LIMIT) begin : g_h_too_big
      $error("vga_timing_gen: horizontal total exceeds 1024");
    end
    if (VT > COORD_LIMIT) begin : g_v_too_big
      $error("vga_timing_gen: vertical total exceeds 1024");
    end
  endgenerate

  coord_t hc_q;
  coord_t vc_q;
  coord_t hc_d;
  coord_t vc_d;
  logic   h_wrap;
  logic   v_wrap;
  logic   blank_q, blank_d;
  logic   hs_q, hs_d;
  logic   vs_q, vs_d;

  vga_wrap_counter #(.MAX(HT), .W($bits(coord_t))) u_hcnt (
    .vga_clk (vga_clk),
    .reset   (reset),
    .en      (1'b1),
    .q       (hc_q),
    .wrap    (h_wrap)
  );

  vga_wrap_counter #(.MAX(VT), .W($bits(coord_t))) u_vcnt (
    .vga_clk (vga_clk),
    .reset   (reset),
    .en      (h_wrap),
    .q       (vc_q),
    .wrap    (v_wrap)
  );

  // Coordinates the counters will hold after this edge; the flags decode these
  always_comb begin
    hc_d = h_wrap ? '0 : hc_q + coord_t'(1);
    vc_d = vc_q;
    if (v_wrap) begin
      vc_d = '0;
    end else if (h_wrap) begin
      vc_d = vc_q + coord_t'(1);
    end
  end

  // Window decode for active video and the two active-low sync pulses
  always_comb begin
    blank_d = in_range(hc_d, '0, coord_t'(H_VISIBLE)) &&
              in_range(vc_d, '0, coord_t'(V_VISIBLE));
    hs_d    = !in_range(hc_d, coord_t'(HS_LO), coord_t'(HS_HI));
    vs_d    = !in_range(vc_d, coord_t'(VS_LO), coord_t'(VS_HI));
  end

  // Flag registers; syncs idle high while in reset
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign DrawX = hc_q;
  assign DrawY = vc_q;
  assign blank = blank_q;
  assign hs    = hs_q;
  assign vs    = vs_q;

`ifdef VGA_FRAME_CNT_EN
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // A frame begins on the edge where both counters wrap together
  always_comb begin
    frame_start_d = v_wrap;
    frame_cnt_d   = frame_cnt_q;
    if (v_wrap) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Frame pulse and free-running frame counter (wraps naturally at 16 bits)
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign frame_start = frame_start_q;
  assign frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a tiny-timing
// instance (short frames). A position model derived from the cycle count since
// reset release fills a scoreboard queue each edge; DUT outputs are popped and
// compared 1 ns later. Window widths, line period and reset behaviour are
// checked separately. Define VGA_FRAME_CNT_EN to also cover the frame outputs.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_d, rst_s;
  logic [9:0] dx, dy, sx, sy;
  logic       db, dhs, dvs, sb, shs, svs;
`ifdef VGA_FRAME_CNT_EN
  logic        dfs, sfs;
  logic [15:0] dfc, sfc;
`endif

  vga_timing_gen u_dflt (
    .vga_clk (clk),
    .reset   (rst_d),
    .DrawX   (dx),
    .DrawY   (dy),
    .blank   (db),
    .hs      (dhs),
    .vs      (dvs)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_start (dfs),
    .frame_count (dfc)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(4)
  ) u_small (
    .vga_clk (clk),
    .reset   (rst_s),
    .DrawX   (sx),
    .DrawY   (sy),
    .blank   (sb),
    .hs      (shs),
    .vs      (svs)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_start (sfs),
    .frame_count (sfc)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reset image of {DrawX, DrawY, blank, hs, vs}
  localparam logic [22:0] RST_VEC = 23'h3;

  int hv, hf, hsy, hb, vv, vf, vsy, vb, ht, vt;
  int sel;
  int n;
  int stat_y, cnt_blank, cnt_hs, cnt_vs, cnt_fs, last_fall, period;
  logic [22:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_timing(input int a, input int b, input int c, input int d,
                            input int e, input int f, input int g, input int h);
    hv = a; hf = b; hsy = c; hb = d; vv = e; vf = f; vsy = g; vb = h;
    ht = a + b + c + d;
    vt = e + f + g + h;
  endtask

  // Expected outputs n edges after reset release, straight from the window formulas
  function automatic logic [22:0] model(input int cyc);
    int p, x, y;
    logic b, h, v;
    p = cyc % (ht * vt);
    x = p % ht;
    y = p / ht;
    b = (x < hv) && (y < vv);
    h = !((x >= hv + hf) && (x < hv + hf + hsy));
    v = !((y >= vv + vf) && (y < vv + vf + vsy));
    return {x[9:0], y[9:0], b, h, v};
  endfunction

  function automatic logic [22:0] observe();
    return (sel != 0) ? {sx, sy, sb, shs, svs} : {dx, dy, db, dhs, dvs};
  endfunction

  function automatic logic obs_fs();
`ifdef VGA_FRAME_CNT_EN
    return (sel != 0) ? sfs : dfs;
`else
    return 1'b0;
`endif
  endfunction

  task automatic clear_stats();
    cnt_blank = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0;
    last_fall = -1; period = -1;
  endtask

  task automatic run(input int cycles);
    logic [22:0] e, o;
    logic prev_vs, prev_hs;
    int yexp;
    o = observe();
    prev_vs = o[0];
    prev_hs = o[1];
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      n++;
      exp_q.push_back(model(n));
      #1;
      o = observe();
      e = exp_q.pop_front();
      check_eq("pixel", 32'(o), 32'(e));
      yexp = int'(e[12:3]);
      if (yexp == stat_y) begin
        if (o[2])  cnt_blank++;
        if (!o[1]) cnt_hs++;
      end
      if (!o[0]) cnt_vs++;
      if (o[0] != prev_vs) check_eq("vs_edge_drawx", 32'(o[22:13]), 32'd0);
      if (prev_hs && !o[1]) begin
        if (last_fall >= 0 && period < 0) period = n - last_fall;
        last_fall = n;
      end
      if (obs_fs()) cnt_fs++;
      prev_vs = o[0];
      prev_hs = o[1];
    end
  endtask

  initial begin
    rst_d = 1'b1;
    rst_s = 1'b1;
    sel   = 0;
    n     = 0;
    stat_y = 0;
    clear_stats();
    set_timing(640, 16, 96, 48, 480, 10, 2, 33);
    repeat (2) @(posedge clk);
    #1;
    sel = 0;
    check_eq("reset_dflt", 32'(observe()), 32'(RST_VEC));
    sel = 1;
    check_eq("reset_small", 32'(observe()), 32'(RST_VEC));
`ifdef VGA_FRAME_CNT_EN
    check_eq("reset_fs", 32'(sfs), 32'd0);
    check_eq("reset_fc", 32'(sfc), 32'd0);
`endif
    $display("txn reset: both instances hold reset values");

    // Tiny timing: three whole frames from reset release
    sel = 1;
    set_timing(20, 3, 5, 4, 12, 2, 3, 4);
    n = 0;
    stat_y = 0;
    clear_stats();
    @(negedge clk);
    rst_s = 1'b0;
    run(3 * ht * vt);
    check_eq("small_blank_y0", 32'(cnt_blank), 32'(3 * hv));
    check_eq("small_hs_low_y0", 32'(cnt_hs), 32'(3 * hsy));
    check_eq("small_vs_low", 32'(cnt_vs), 32'(3 * vsy * ht));
    check_eq("small_line_period", 32'(period), 32'(ht));
`ifdef VGA_FRAME_CNT_EN
    check_eq("small_frame_pulses", 32'(cnt_fs), 32'd3);
    check_eq("small_frame_count", 32'(sfc), 32'd3);
    force u_small.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release u_small.frame_cnt_q;
    run(ht * vt);
    check_eq("frame_count_wrap", 32'(sfc), 32'd0);
`endif
    $display("txn small: %0d frames of %0dx%0d, blank=%0d hs=%0d vs=%0d period=%0d",
             3, ht, vt, cnt_blank, cnt_hs, cnt_vs, period);

    // Async reset in the middle of a frame, checked before any clock edge
    run(100);
    #2;
    rst_s = 1'b1;
    #1;
    check_eq("async_reset_small", 32'(observe()), 32'(RST_VEC));
`ifdef VGA_FRAME_CNT_EN
    check_eq("async_reset_fc", 32'(sfc), 32'd0);
`endif
    $display("txn small: async reset mid-frame");

    // Default 640x480 timing: two lines, stats on line 1
    sel = 0;
    set_timing(640, 16, 96, 48, 480, 10, 2, 33);
    n = 0;
    stat_y = 1;
    clear_stats();
    @(negedge clk);
    rst_d = 1'b0;
    run(2 * ht);
    check_eq("dflt_blank_line", 32'(cnt_blank), 32'd640);
    check_eq("dflt_hs_low_line", 32'(cnt_hs), 32'd96);
    check_eq("dflt_line_period", 32'(period), 32'd800);
    check_eq("dflt_vs_idle", 32'(cnt_vs), 32'd0);
    $display("txn dflt: two lines, blank=%0d hs=%0d period=%0d", cnt_blank, cnt_hs, period);

    run(300);
    check_eq("dflt_drawx_300", 32'(dx), 32'd300);
    #2;
    rst_d = 1'b1;
    #1;
    check_eq("async_reset_dflt", 32'(observe()), 32'(RST_VEC));
    $display("txn dflt: async reset mid-line");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
